logic_unit_arbiter: RTL and testbench

LOGIC_UNIT_ARBITER -- requirements
Module: logic_unit_arbiter

---
 rtl/logic_unit_arbiter.sv | 153 +++++++++++++++
 tb/tb_logic_unit_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_arbiter.sv
// rtl/logic_unit_arbiter.sv - two-requester round-robin front end for a shared 64-bit logic unit (optional flags: LOGIC_UNIT_ARBITER_FLAGS_EN)
module logic_unit_arbiter #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [63:0] req0_a,
  input  logic [63:0] req0_b,
  input  logic [1:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [63:0] req1_a,
  input  logic [63:0] req1_b,
  input  logic [1:0]  req1_op,
  output logic [63:0] lu_a,
  output logic [63:0] lu_b,
  output logic [1:0]  lu_op,
  input  logic [63:0] lu_result,
  input  logic        lu_zero,
  input  logic        lu_negative,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [63:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_negative
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

  state_t      state_q;
  state_t      state_d;
  logic [3:0]  count_q;
  logic        last_grant_q;
  logic        grant0;
  logic        grant1;
  logic        accept;
  logic        accept_id;
  logic        settle_done;
  logic [63:0] lu_a_q;
  logic [63:0] lu_b_q;
  logic [1:0]  lu_op_q;
  logic        rsp_id_q;
  logic [63:0] rsp_result_q;

  // Pick a requester: a lone valid wins, contention goes to the one not served last
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      grant0 = last_grant_q;
      grant1 = !last_grant_q;
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
  end

  // Readies are offered only while idle and out of reset, so at most one is ever high
  assign req0_ready  = reset_n && (state_q == IDLE) && grant0;
  assign req1_ready  = reset_n && (state_q == IDLE) && grant1;
  assign accept      = req0_ready || req1_ready;
  assign accept_id   = req1_ready;
  assign settle_done = (state_q == WAIT) && (count_q == 4'd1);

  // Next-state logic: accept -> settle countdown -> hold response until taken
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = WAIT;
      WAIT:    if (count_q == 4'd1) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand drive, settle counter, grant history and result capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q      <= 4'd0;
      last_grant_q <= 1'b1;
      lu_a_q       <= 64'd0;
      lu_b_q       <= 64'd0;
      lu_op_q      <= 2'd0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= 64'd0;
    end else begin
      if (accept) begin
        lu_a_q       <= accept_id ? req1_a : req0_a;
        lu_b_q       <= accept_id ? req1_b : req0_b;
        lu_op_q      <= accept_id ? req1_op : req0_op;
        rsp_id_q     <= accept_id;
        last_grant_q <= accept_id;
        count_q      <= SETTLE_LOAD;
      end else if (state_q == WAIT) begin
        count_q <= count_q - 4'd1;
      end
      if (settle_done) begin
        rsp_result_q <= lu_result;
      end
    end
  end

`ifdef LOGIC_UNIT_ARBITER_FLAGS_EN
  logic rsp_zero_q;
  logic rsp_negative_q;

  // Flags are sampled on the same edge as the result
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_zero_q     <= 1'b0;
      rsp_negative_q <= 1'b0;
    end else if (settle_done) begin
      rsp_zero_q     <= lu_zero;
      rsp_negative_q <= lu_negative;
    end
  end

  assign rsp_zero     = rsp_zero_q;
  assign rsp_negative = rsp_negative_q;
`else
  logic unused_flags;

  assign unused_flags = lu_zero ^ lu_negative;
  assign rsp_zero     = 1'b0;
  assign rsp_negative = 1'b0;
`endif

  assign lu_a       = lu_a_q;
  assign lu_b       = lu_b_q;
  assign lu_op      = lu_op_q;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb/tb_logic_unit_arbiter.sv - randomized model-checked bench for logic_unit_arbiter at SETTLE_CYCLES 2, 1 and 15
module tb_logic_unit_arbiter;

  localparam int NDUT = 3;

`ifdef LOGIC_UNIT_ARBITER_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  function automatic int settle_of(input int k);
    return (k == 0) ? 2 : (k == 1) ? 1 : 15;
  endfunction

  function automatic logic [63:0] lu_f(input logic [63:0] x, input logic [63:0] y, input logic [1:0] o);
    case (o)
      2'd0:    return x & y;
      2'd1:    return x | y;
      2'd2:    return x ^ y;
      default: return ~x;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        v    [NDUT][2];
  logic [63:0] a    [NDUT][2];
  logic [63:0] b    [NDUT][2];
  logic [1:0]  op   [NDUT][2];
  logic        rdy  [NDUT][2];
  logic [63:0] lua  [NDUT];
  logic [63:0] lub  [NDUT];
  logic [1:0]  luop [NDUT];
  logic [63:0] lures[NDUT];
  logic        luz  [NDUT];
  logic        lun  [NDUT];
  logic        rv   [NDUT];
  logic        rr   [NDUT];
  logic        rid  [NDUT];
  logic [63:0] rres [NDUT];
  logic        rz   [NDUT];
  logic        rn   [NDUT];

  always #5 clk = ~clk;

  for (genvar k = 0; k < NDUT; k++) begin : g_dut
    localparam int SK = (k == 0) ? 2 : (k == 1) ? 1 : 15;
    assign lures[k] = lu_f(lua[k], lub[k], luop[k]);
    assign luz[k]   = (lures[k] == 64'd0);
    assign lun[k]   = lures[k][63];
    logic_unit_arbiter #(.SETTLE_CYCLES(SK)) u_dut (
      .clk(clk), .reset_n(reset_n),
      .req0_valid(v[k][0]), .req0_ready(rdy[k][0]),
      .req0_a(a[k][0]), .req0_b(b[k][0]), .req0_op(op[k][0]),
      .req1_valid(v[k][1]), .req1_ready(rdy[k][1]),
      .req1_a(a[k][1]), .req1_b(b[k][1]), .req1_op(op[k][1]),
      .lu_a(lua[k]), .lu_b(lub[k]), .lu_op(luop[k]),
      .lu_result(lures[k]), .lu_zero(luz[k]), .lu_negative(lun[k]),
      .rsp_valid(rv[k]), .rsp_ready(rr[k]), .rsp_id(rid[k]),
      .rsp_result(rres[k]), .rsp_zero(rz[k]), .rsp_negative(rn[k])
    );
  end

  // Transaction-level model: outstanding op, edges since its accept, last served requester
  bit          m_busy  [NDUT];
  int          m_cyc   [NDUT];
  int          m_acc   [NDUT];
  logic [63:0] m_a     [NDUT];
  logic [63:0] m_b     [NDUT];
  logic [1:0]  m_op    [NDUT];
  logic        m_id    [NDUT];
  logic        m_last  [NDUT];
  logic [63:0] m_st_res[NDUT];
  logic        m_st_z  [NDUT];
  logic        m_st_n  [NDUT];
  logic        model_acc[NDUT][2];
  int          acc_log[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset(input int k);
    m_busy[k] = 1'b0;  m_cyc[k] = 0;  m_acc[k] = 0;
    m_a[k] = '0;  m_b[k] = '0;  m_op[k] = '0;  m_id[k] = 1'b0;  m_last[k] = 1'b1;
    m_st_res[k] = '0;  m_st_z[k] = 1'b0;  m_st_n[k] = 1'b0;
    model_acc[k][0] = 1'b0;  model_acc[k][1] = 1'b0;
    if (k == 0) acc_log.delete();
  endtask

  task automatic model_step();
    int e;
    logic [63:0] cur, exp_res;
    logic exp_rv, ez, en, idle, win, er0, er1;
    for (int k = 0; k < NDUT; k++) begin
      if (!reset_n) model_reset(k);
      e       = m_cyc[k] - m_acc[k];
      exp_rv  = m_busy[k] && (e >= settle_of(k));
      cur     = lu_f(m_a[k], m_b[k], m_op[k]);
      exp_res = exp_rv ? cur : m_st_res[k];
      ez      = FLAGS && (exp_rv ? (cur == 64'd0) : m_st_z[k]);
      en      = FLAGS && (exp_rv ? cur[63] : m_st_n[k]);
      idle    = reset_n && !m_busy[k];
      win     = (v[k][0] && v[k][1]) ? !m_last[k] : v[k][1];
      er0     = idle && v[k][0] && !win;
      er1     = idle && v[k][1] && win;
      chk($sformatf("dut%0d req0_ready", k), rdy[k][0], er0);
      chk($sformatf("dut%0d req1_ready", k), rdy[k][1], er1);
      chk($sformatf("dut%0d both_ready", k), rdy[k][0] && rdy[k][1], 0);
      chk($sformatf("dut%0d rsp_valid", k), rv[k], exp_rv);
      chk($sformatf("dut%0d rsp_id", k), rid[k], m_id[k]);
      chk($sformatf("dut%0d rsp_result", k), rres[k], exp_res);
      chk($sformatf("dut%0d rsp_zero", k), rz[k], ez);
      chk($sformatf("dut%0d rsp_negative", k), rn[k], en);
      chk($sformatf("dut%0d lu_a", k), lua[k], m_a[k]);
      chk($sformatf("dut%0d lu_b", k), lub[k], m_b[k]);
      chk($sformatf("dut%0d lu_op", k), luop[k], m_op[k]);
      if (reset_n) begin
        model_acc[k][0] = er0;
        model_acc[k][1] = er1;
        if (exp_rv && rr[k]) begin
          m_busy[k]   = 1'b0;
          m_st_res[k] = cur;
          m_st_z[k]   = (cur == 64'd0);
          m_st_n[k]   = cur[63];
        end
        m_cyc[k]++;
        if (er0 || er1) begin
          m_busy[k] = 1'b1;  m_acc[k] = m_cyc[k];
          m_a[k] = a[k][win];  m_b[k] = b[k][win];  m_op[k] = op[k][win];
          m_id[k] = win;  m_last[k] = win;
          if (k == 0) acc_log.push_back(int'(win));
        end
      end
    end
  endtask

  task automatic drive_req(input int n, input logic val, input logic [63:0] av, input logic [63:0] bv, input logic [1:0] o);
    for (int k = 0; k < NDUT; k++) begin
      v[k][n] = val;  a[k][n] = av;  b[k][n] = bv;  op[k][n] = o;
    end
  endtask

  task automatic set_rsp_ready(input logic r);
    for (int k = 0; k < NDUT; k++) rr[k] = r;
  endtask

  task automatic run_stimulus();
    int lat[NDUT];
    int cnt;
    bit found;
    int sel;
    // Reset with req0 already valid: no ready may show while reset is held
    repeat (3) @(negedge clk);
    #3;
    chk("reset rsp_valid", rv[0], 0);
    chk("reset req0_ready", rdy[0][0], 0);
    chk("reset lu_a", lua[0], 0);
    chk("reset rsp_result", rres[0], 0);
    // Single request, response held off for 20 cycles while req1 waits
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < NDUT; k++) lat[k] = -1;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      if (j == 1) begin
        drive_req(0, 1'b0, 64'd0, 64'd0, 2'b00);
        drive_req(1, 1'b1, 64'd0, 64'd0, 2'b01);
      end
      #3;
      for (int k = 0; k < NDUT; k++) begin
        if (rv[k] && lat[k] < 0) lat[k] = j - 1;
        chk($sformatf("stall dut%0d req1_ready", k), rdy[k][1], 0);
      end
    end
    chk("latency S=2", lat[0], 2);
    chk("latency S=1", lat[1], 1);
    chk("latency S=15", lat[2], 15);
    chk("or rsp_id", rid[0], 0);
    chk("or rsp_result", rres[0], 64'hFFFF_FFFF_FFFF_FFFF);
    chk("or rsp_zero", rz[0], 0);
    chk("or rsp_negative", rn[0], FLAGS ? 1 : 0);
    // Release the response; req1's zero operands come next
    @(negedge clk);
    set_rsp_ready(1'b1);
    found = 0;
    for (int t = 0; t < 30 && !found; t++) begin
      @(negedge clk);
      #3;
      if (rv[0] && rid[0]) found = 1;
    end
    chk("req1 response seen", found, 1);
    if (found) begin
      chk("zero rsp_result", rres[0], 0);
      chk("zero rsp_zero", rz[0], FLAGS ? 1 : 0);
      chk("zero rsp_negative", rn[0], 0);
    end
    // Continuous contention after reset alternates 0,1,0,1
    reset_n = 1'b0;
    drive_req(0, 1'b1, 64'h0F0F, 64'h00FF, 2'b00);
    drive_req(1, 1'b1, 64'hAAAA, 64'h5555, 2'b10);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("alternation count", acc_log.size() >= 4, 1);
    for (int i = 0; i < 4; i++) begin
      if (acc_log.size() > i) chk($sformatf("alternation[%0d]", i), acc_log[i], i % 2);
    end
    // Reset during the settle wait aborts the operation
    reset_n = 1'b0;
    drive_req(1, 1'b0, 64'd0, 64'd0, 2'b00);
    drive_req(0, 1'b1, 64'h1234, 64'h5678, 2'b10);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    drive_req(0, 1'b0, 64'd0, 64'd0, 2'b00);
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b0;
    @(negedge clk);
    #3;
    chk("abort rsp_valid", rv[2], 0);
    chk("abort lu_a", lua[2], 0);
    chk("abort lu_op", luop[2], 0);
    chk("abort req0_ready", rdy[2][0], 0);
    @(negedge clk);
    reset_n = 1'b1;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      #3;
      if (rv[2]) cnt++;
    end
    chk("abort no response", cnt, 0);
    // Randomized traffic; a pending request holds until taken
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int k = 0; k < NDUT; k++) begin
        for (int n = 0; n < 2; n++) begin
          if (!(v[k][n] && !model_acc[k][n])) begin
            v[k][n]  = ($urandom_range(0, 99) < 60);
            a[k][n]  = {$urandom, $urandom};
            b[k][n]  = {$urandom, $urandom};
            op[k][n] = 2'($urandom_range(0, 3));
            sel = $urandom_range(0, 7);
            if (sel == 0) a[k][n] = 64'd0;
            if (sel == 1) b[k][n] = a[k][n];
            if (sel == 2) b[k][n] = 64'd0;
          end
        end
        rr[k] = ($urandom_range(0, 99) < 50);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < NDUT; k++) begin
      rr[k] = 1'b0;
      model_acc[k][0] = 1'b0;
      model_acc[k][1] = 1'b0;
    end
    drive_req(0, 1'b1, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 2'b01);
    drive_req(1, 1'b0, 64'd0, 64'd0, 2'b00);
    fork
      begin
        forever begin
          @(negedge clk);
          #2;
          model_step();
        end
      end
      begin
        run_stimulus();
      end
    join_any
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
